pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/pipeline controller for the 5-stage core (F,D,E,M,W).
//  - Tracks valid, rd, RegWrite and load flag of the instructions in D, E, M and W.
//  - Drives stage enables (stall), bubble/flush, E-stage forwarding selects and perf counters.
//  - Replaces the free-running enable on the stage pipo registers.
//  - FORWARDING selects a bypass build or a stall-only build.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register-index width (reg_addr_t)
//  FORWARDING      1   1: M/W->E bypass, stall only on load-use; 0: stall on any RAW vs E/M/W
//  CNT_WIDTH       32  width of each saturating perf counter
// PORTS
//  clk             in   1    core clock
//  reset           in   1    synchronous, active-high
//  fetch_valid_f   in   1    instruction memory produced a valid InstrF this cycle
//  rs1_d, rs2_d    in   RAW  D-stage source indices (RAW = REG_ADDR_WIDTH)
//  use_rs1_d       in   1    D instruction reads rs1
//  use_rs2_d       in   1    D instruction reads rs2
//  rd_d            in   RAW  D-stage destination index
//  regwrite_d      in   1    D instruction writes rd
//  load_d          in   1    D instruction is a load (ResultSrc==RESULT_MEM)
//  redirect_e      in   1    PCSrcE: taken branch/jump resolved in E
//  stall_f         out  1    hold PC register
//  stall_d         out  1    hold F/D register
//  flush_d         out  1    clear F/D register
//  flush_e         out  1    clear D/E register (insert bubble)
//  fwd_a_e         out  2    SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  fwd_b_e         out  2    SrcB/WriteData select, same encoding
//  valid_e, valid_m, valid_w  out 1 each  stage occupancy
//  retire_w        out  1    pulse: valid instruction in W this cycle
//  stall_cnt       out  CNT_WIDTH  cycles with stall_d=1
//  flush_cnt       out  CNT_WIDTH  cycles with an effective redirect
//  retire_cnt      out  CNT_WIDTH  retired instructions
// BEHAVIOUR
//  - State: valid_d; per E/M/W slot {valid, rd, regwrite, load}; E slot also holds rs1/rs2/use bits.
//  - Reset (sync): all valids 0, counters 0.
//    Outputs during/after reset: stalls 0, flushes 0, fwd 00, retire_w 0.
//  - Decode and control are combinational from state + D inputs; zero-cycle latency.
//  - Write match "X hits r": valid_X & regwrite_X & rd_X==r & r!=0.
//  - Load-use hazard: valid_d & E.load & E hits (use_rs1_d?rs1_d) or (use_rs2_d?rs2_d).
//  - With FORWARDING=0, hazard additionally covers E, M or W hitting a used D source.
//    Regfile is write-first, so W-stage hits are exempt.
//  - redir = redirect_e & valid_e.
//    - flush_d = redir; flush_e = redir | hazard.
//    - stall_f = stall_d = hazard & ~redir; redirect wins over stall.
//  - Forwarding (FORWARDING=1): fwd_a_e = M hits rs1_e & use_rs1_e ? 10 : W hits ? 01 : 00.
//    fwd_b_e same on rs2_e; M has priority over W. With FORWARDING=0 both selects stay 00.
//  - Next state each clock:
//    - valid_d <= redir ? 0 : stall_d ? valid_d : fetch_valid_f.
//    - E <= flush_e ? bubble (valid 0) : D info with valid_d; M <= E; W <= M.
//  - Counters saturate at all-ones and never wrap.
//    - stall_cnt++ on stall_d; flush_cnt++ on redir; retire_cnt++ on retire_w.
//  - retire_w = valid_w. Bubbles never retire. rd=x0 never causes stall or forward.
//  - Reset mid-stream drops all in-flight state at that edge; no partial retire.
// TESTING
//  - addi x1; add x2,x1,x1 back-to-back (FWD=1) -> no stall, fwd_a_e=fwd_b_e=10 on add in E.
//  - lw x5; add x6,x5,x0 -> 1 stall cycle, one bubble in E, then fwd_a_e=01; stall_cnt=1.
//  - Same pair with FORWARDING=0 -> 3 stall cycles (E,M,W... W exempt: 2); fwd stays 00.
//  - beq taken (redirect_e=1) while D holds load-use -> flush_d=flush_e=1, stall_d=0, flush_cnt=1.
//  - Writes to x0 followed by reads of x0 -> no stall, fwd 00; 10 instrs -> retire_cnt=10.
//  - CNT_WIDTH=4, 20 stalls -> stall_cnt=15; reset mid-run -> all counters 0, valids 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush, E-stage forwarding and perf counters for the 5-stage core
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FORWARDING = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid_f,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic                      use_rs1_d,
  input  logic                      use_rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      regwrite_d,
  input  logic                      load_d,
  input  logic                      redirect_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [1:0]                fwd_a_e,
  output logic [1:0]                fwd_b_e,
  output logic                      valid_e,
  output logic                      valid_m,
  output logic                      valid_w,
  output logic                      retire_w,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [CNT_WIDTH-1:0]      retire_cnt
);
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      regwrite;
  } dst_t;
  typedef struct packed {
    dst_t      dst;
    logic      load;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      use_rs1;
    logic      use_rs2;
  } ex_t;
  logic valid_d_q;
  ex_t  e_q;
  dst_t m_q, w_q;
  logic load_use, raw_em, hazard, redir, fwd_en;
  function automatic logic hits(dst_t s, reg_addr_t r);
    return s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction
  always_comb begin
    load_use = e_q.load & ((use_rs1_d & hits(e_q.dst, rs1_d)) | (use_rs2_d & hits(e_q.dst, rs2_d)));
    raw_em = (use_rs1_d & (hits(e_q.dst, rs1_d) | hits(m_q, rs1_d)))
           | (use_rs2_d & (hits(e_q.dst, rs2_d) | hits(m_q, rs2_d)));
    hazard = ~reset & valid_d_q & (FORWARDING != 0 ? load_use : raw_em);
    redir = ~reset & redirect_e & e_q.dst.valid;
    fwd_en = ~reset & (FORWARDING != 0);
  end
  assign flush_d = redir;
  assign flush_e = redir | hazard;
  assign stall_d = hazard & ~redir;
  assign stall_f = stall_d;
  assign fwd_a_e = fwd_en & e_q.use_rs1 & hits(m_q, e_q.rs1) ? 2'b10
                 : fwd_en & e_q.use_rs1 & hits(w_q, e_q.rs1) ? 2'b01 : 2'b00;
  assign fwd_b_e = fwd_en & e_q.use_rs2 & hits(m_q, e_q.rs2) ? 2'b10
                 : fwd_en & e_q.use_rs2 & hits(w_q, e_q.rs2) ? 2'b01 : 2'b00;
  assign valid_e = e_q.dst.valid;
  assign valid_m = m_q.valid;
  assign valid_w = w_q.valid;
  assign retire_w = ~reset & w_q.valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d_q <= 1'b0;
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      valid_d_q <= redir ? 1'b0 : stall_d ? valid_d_q : fetch_valid_f;
      e_q <= flush_e ? '0 : {valid_d_q, rd_d, regwrite_d, load_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d};
      m_q <= e_q.dst;
      w_q <= m_q;
      stall_cnt <= stall_cnt + CNT_WIDTH'(stall_d & ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_WIDTH'(redir & ~&flush_cnt);
      retire_cnt <= retire_cnt + CNT_WIDTH'(retire_w & ~&retire_cnt);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed table, corner sequences and random run against a stage-list model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, fetch_valid_f, use_rs1_d, use_rs2_d, regwrite_d, load_d, redirect_e;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic stall_f_o [3];
  logic stall_d_o [3];
  logic flush_d_o [3];
  logic flush_e_o [3];
  logic valid_e_o [3];
  logic valid_m_o [3];
  logic valid_w_o [3];
  logic retire_o [3];
  logic [1:0] fwd_a_o [3];
  logic [1:0] fwd_b_o [3];
  logic [31:0] sc_o [3];
  logic [31:0] fc_o [3];
  logic [31:0] rc_o [3];
  int checks = 0;
  int errors = 0;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CW = g == 2 ? 4 : 32;
    logic [CW-1:0] sc, fc, rc;
    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .FORWARDING(g == 1 ? 0 : 1), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .fetch_valid_f(fetch_valid_f),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .redirect_e(redirect_e),
      .stall_f(stall_f_o[g]), .stall_d(stall_d_o[g]), .flush_d(flush_d_o[g]), .flush_e(flush_e_o[g]),
      .fwd_a_e(fwd_a_o[g]), .fwd_b_e(fwd_b_o[g]),
      .valid_e(valid_e_o[g]), .valid_m(valid_m_o[g]), .valid_w(valid_w_o[g]), .retire_w(retire_o[g]),
      .stall_cnt(sc), .flush_cnt(fc), .retire_cnt(rc));
    assign sc_o[g] = 32'(sc);
    assign fc_o[g] = 32'(fc);
    assign rc_o[g] = 32'(rc);
  end
  typedef struct {bit v; int rd; bit rw, ld; int rs1, rs2; bit u1, u2;} ins_t;
  typedef struct {bit stall, fd, fe, ret; int fa, fb;} mo_t;
  ins_t st [3][4];
  longint msc [3];
  longint mfc [3];
  longint mrc [3];
  mo_t mo [3];
  bit use_model = 0;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask
  function automatic bit prod(int i, int k, int r);
    return st[i][k].v && st[i][k].rw && st[i][k].rd == r && r != 0;
  endfunction
  function automatic int fsel(int i, bit u, int r);
    if (i == 1 || reset || !u) return 0;
    if (prod(i, 2, r)) return 2;
    if (prod(i, 3, r)) return 1;
    return 0;
  endfunction
  task automatic eval();
    for (int i = 0; i < 3; i++) begin
      bit fwd, haz, red;
      fwd = i != 1;
      haz = 0;
      for (int k = 1; k <= (fwd ? 1 : 2); k++)
        if ((!fwd || st[i][k].ld) && ((use_rs1_d && prod(i, k, rs1_d)) || (use_rs2_d && prod(i, k, rs2_d))))
          haz = 1;
      haz = haz && st[i][0].v && !reset;
      red = redirect_e && st[i][1].v && !reset;
      mo[i].fd = red;
      mo[i].fe = red || haz;
      mo[i].stall = haz && !red;
      mo[i].fa = fsel(i, st[i][1].u1, st[i][1].rs1);
      mo[i].fb = fsel(i, st[i][1].u2, st[i][1].rs2);
      mo[i].ret = st[i][3].v && !reset;
    end
  endtask
  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      longint mx;
      mx = i == 2 ? 15 : 64'hFFFF_FFFF;
      if (reset) begin
        for (int k = 0; k < 4; k++) st[i][k] = '{default: 0};
        msc[i] = 0;
        mfc[i] = 0;
        mrc[i] = 0;
      end else begin
        if (mo[i].stall && msc[i] < mx) msc[i]++;
        if (mo[i].fd && mfc[i] < mx) mfc[i]++;
        if (mo[i].ret && mrc[i] < mx) mrc[i]++;
        st[i][3] = st[i][2];
        st[i][2] = st[i][1];
        st[i][1] = mo[i].fe ? '{default: 0} : '{v: st[i][0].v, rd: rd_d, rw: regwrite_d, ld: load_d,
                                                 rs1: rs1_d, rs2: rs2_d, u1: use_rs1_d, u2: use_rs2_d};
        st[i][0].v = mo[i].fd ? 1'b0 : mo[i].stall ? st[i][0].v : fetch_valid_f;
      end
    end
  endtask
  task automatic cmp_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d.stall_d", i), stall_d_o[i], mo[i].stall);
      chk($sformatf("m%0d.stall_f", i), stall_f_o[i], mo[i].stall);
      chk($sformatf("m%0d.flush_d", i), flush_d_o[i], mo[i].fd);
      chk($sformatf("m%0d.flush_e", i), flush_e_o[i], mo[i].fe);
      chk($sformatf("m%0d.fwd_a", i), fwd_a_o[i], mo[i].fa);
      chk($sformatf("m%0d.fwd_b", i), fwd_b_o[i], mo[i].fb);
      chk($sformatf("m%0d.valid_e", i), valid_e_o[i], st[i][1].v);
      chk($sformatf("m%0d.valid_m", i), valid_m_o[i], st[i][2].v);
      chk($sformatf("m%0d.valid_w", i), valid_w_o[i], st[i][3].v);
      chk($sformatf("m%0d.retire", i), retire_o[i], mo[i].ret);
      chk($sformatf("m%0d.stall_cnt", i), sc_o[i], msc[i]);
      chk($sformatf("m%0d.flush_cnt", i), fc_o[i], mfc[i]);
      chk($sformatf("m%0d.retire_cnt", i), rc_o[i], mrc[i]);
    end
  endtask
  task automatic settle();
    #1;
    eval();
    if (use_model) cmp_model();
  endtask
  task automatic clock();
    @(posedge clk);
    advance();
    #1;
  endtask
  task automatic drive(bit rst, bit fv, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit ld, bit br);
    reset = rst;
    fetch_valid_f = fv;
    rs1_d = 5'(rs1);
    rs2_d = 5'(rs2);
    use_rs1_d = u1;
    use_rs2_d = u2;
    rd_d = 5'(rd);
    regwrite_d = rw;
    load_d = ld;
    redirect_e = br;
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    clock();
    use_model = 1;
    settle();
    clock();
  endtask
  typedef struct {
    bit rst, fv; int rs1, rs2; bit u1, u2; int rd; bit rw, ld, br;
    bit st, fd, fe; int fa, fb; bit ret; int cs, cr, cf;
  } vec_t;
  vec_t tbl [18];
  initial begin
    tbl[0]  = '{1,0, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 0, 0,0,0};
    tbl[1]  = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 0, 0,0,0};
    tbl[2]  = '{0,1, 0,0,0,0, 1,1,0,0,  0,0,0, 0,0, 0, 0,0,0};
    tbl[3]  = '{0,1, 1,1,1,1, 2,1,0,0,  0,0,0, 0,0, 0, 0,0,0};
    tbl[4]  = '{0,1, 0,0,0,0, 5,1,1,0,  0,0,0, 2,2, 0, 0,0,0};
    tbl[5]  = '{0,1, 5,0,1,1, 6,1,0,0,  1,0,1, 0,0, 1, 0,0,0};
    tbl[6]  = '{0,1, 5,0,1,1, 6,1,0,0,  0,0,0, 0,0, 1, 1,1,0};
    tbl[7]  = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 1,0, 1, 1,2,0};
    tbl[8]  = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 0, 1,3,0};
    tbl[9]  = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 1, 1,3,0};
    tbl[10] = '{0,1, 0,0,0,0, 7,1,1,0,  0,0,0, 0,0, 1, 1,4,0};
    tbl[11] = '{0,1, 7,0,1,0, 8,1,0,1,  0,1,1, 0,0, 1, 1,5,0};
    tbl[12] = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 1, 1,6,1};
    tbl[13] = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 1, 1,7,1};
    tbl[14] = '{0,1, 0,0,0,0, 0,1,0,0,  0,0,0, 0,0, 0, 1,8,1};
    tbl[15] = '{0,1, 0,0,0,0, 0,1,1,0,  0,0,0, 0,0, 0, 1,8,1};
    tbl[16] = '{0,1, 0,0,1,1, 0,1,0,0,  0,0,0, 0,0, 1, 1,8,1};
    tbl[17] = '{0,1, 0,0,0,0, 0,0,0,0,  0,0,0, 0,0, 1, 1,9,1};
    do_reset();
    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].rst, tbl[r].fv, tbl[r].rs1, tbl[r].rs2, tbl[r].u1, tbl[r].u2,
            tbl[r].rd, tbl[r].rw, tbl[r].ld, tbl[r].br);
      settle();
      chk($sformatf("t%0d.stall_d", r), stall_d_o[0], tbl[r].st);
      chk($sformatf("t%0d.stall_f", r), stall_f_o[0], tbl[r].st);
      chk($sformatf("t%0d.flush_d", r), flush_d_o[0], tbl[r].fd);
      chk($sformatf("t%0d.flush_e", r), flush_e_o[0], tbl[r].fe);
      chk($sformatf("t%0d.fwd_a", r), fwd_a_o[0], tbl[r].fa);
      chk($sformatf("t%0d.fwd_b", r), fwd_b_o[0], tbl[r].fb);
      chk($sformatf("t%0d.retire", r), retire_o[0], tbl[r].ret);
      chk($sformatf("t%0d.stall_cnt", r), sc_o[0], tbl[r].cs);
      chk($sformatf("t%0d.retire_cnt", r), rc_o[0], tbl[r].cr);
      chk($sformatf("t%0d.flush_cnt", r), fc_o[0], tbl[r].cf);
      clock();
    end
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    clock();
    drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    settle();
    clock();
    drive(0, 1, 5, 0, 1, 1, 6, 1, 0, 0);
    settle();
    chk("nofwd.stall1", stall_d_o[1], 1);
    chk("fwd.stall1", stall_d_o[0], 1);
    clock();
    settle();
    chk("nofwd.stall2", stall_d_o[1], 1);
    chk("fwd.stall2", stall_d_o[0], 0);
    clock();
    settle();
    chk("nofwd.stall3", stall_d_o[1], 0);
    chk("nofwd.fwd_a", fwd_a_o[1], 0);
    clock();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("nofwd.stall_cnt", sc_o[1], 2);
    chk("fwd.stall_cnt", sc_o[0], 1);
    clock();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(0, c < 10, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      clock();
    end
    settle();
    chk("ten.retire_cnt", rc_o[0], 10);
    clock();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    clock();
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
      else drive(0, 1, 5, 0, 1, 0, 6, 1, 0, 0);
      settle();
      clock();
    end
    settle();
    chk("sat.stall_cnt32", sc_o[0], 20);
    chk("sat.stall_cnt4", sc_o[2], 15);
    clock();
    drive(1, 1, 5, 0, 1, 0, 6, 1, 0, 1);
    settle();
    chk("rst.stall_d", stall_d_o[2], 0);
    chk("rst.retire", retire_o[2], 0);
    clock();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.stall_cnt", i), sc_o[i], 0);
      chk($sformatf("rst%0d.retire_cnt", i), rc_o[i], 0);
      chk($sformatf("rst%0d.valids", i), {valid_e_o[i], valid_m_o[i], valid_w_o[i]}, 0);
    end
    clock();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      settle();
      clock();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
